ctrl_valores_fecha: RTL
=======================

Name: ctrl_valores_fecha

Overview:
- Date-value controller for the date-adjust mode.
- Consumes the one-hot field selects (day/month/year) and debounced up/down pulses.
- Holds the edited day, month and year with calendar-correct wrap and clamping.
- On leaving adjust mode, sequences a three-write burst of BCD values to the RTC write interface using a req/ack handshake.

Parameters:
- ADDR_DIA, 8'h24, RTC register address for day
- ADDR_MES, 8'h25, RTC register address for month
- ADDR_YEAR, 8'h26, RTC register address for year (two-digit, 00-99)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- sw_fecha  input  1  date-adjust mode switch (level)
- a_dia  input  1  day field selected
- a_mes  input  1  month field selected
- a_year  input  1  year field selected
- inc  input  1  single-cycle increment pulse
- dec  input  1  single-cycle decrement pulse
- dia_in  input  5  current day from RTC read path (binary)
- mes_in  input  4  current month (binary)
- year_in  input  7  current year 0-99 (binary)
- wr_ack  input  1  write interface acknowledge (single-cycle)
- dia  output  5  edited day (binary)
- mes  output  4  edited month (binary)
- year  output  7  edited year (binary)
- wr_req  output  1  write request
- wr_addr  output  8  write address
- wr_data  output  8  write data, BCD
- busy  output  1  high outside IDLE

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high; all outputs are registered.
  - Reset values: dia=1, mes=1, year=0, wr_req=0, wr_addr=0, wr_data=0, busy=0, state=IDLE.
  - Reset mid-burst drops wr_req on the next edge with no further writes.
- States: IDLE, LOAD, EDIT, WR_DIA, WR_MES, WR_YEAR.
  - IDLE: on sw_fecha rising edge (registered previous value), go to LOAD.
  - LOAD: capture dia_in, mes_in, year_in into dia, mes, year; go to EDIT (one cycle).
  - EDIT: see field editing below; on sw_fecha falling edge, go to WR_DIA.
  - WR_x: drive wr_req=1 with wr_addr=ADDR_x and wr_data=BCD(field).
    - Hold all three until the cycle wr_ack=1; on that edge advance to the next state (WR_DIA, WR_MES, WR_YEAR, then IDLE).
    - wr_req deasserts on the same edge that leaves WR_YEAR.
  - wr_ack outside WR_x states is ignored.
  - sw_fecha changes during WR_x or LOAD are ignored; a pending rising edge is not remembered.
- Field editing in EDIT:
  - Select priority: dia > mes > year when more than one select is high. No select means no change.
  - inc and dec in the same cycle means no change.
  - dia wraps max to 1 on inc and 1 to max on dec.
  - mes wraps 12 to 1 and 1 to 12.
  - year wraps 99 to 0 and 0 to 99.
  - Month maximum: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; February per the optional feature.
  - Clamp: when mes or year changes, dia is recomputed in the same edge against the new value. If dia > new max, dia = new max.
  - Latency: a pulse sampled at edge N is visible on outputs after edge N.
- Input sanitising: out-of-range loaded inputs (dia 0 or >31, mes 0 or >12, year >99) load as 1, 1, 0 respectively.

Optional Feature:
- Macro: LEAP_YEAR_EN.
- Defined:
  - February max is 29 when year[1:0]==0, else 28.
  - Year changes re-clamp dia, so 29 goes to 28 on a non-leap year.
- Undefined:
  - February max is always 28.
  - Year changes never alter dia.

Decomposition:
- Shared package fecha_pkg:
  - state encoding constants
  - default RTC addresses 8'h24/8'h25/8'h26
  - field min/max constants (12, 99)
  - a days-in-month function taking mes and year
- One natural sub-module, bin_a_bcd: 7-bit binary 0-99 in, 8-bit BCD out, combinational. It is instantiated once on the wr_data mux output.

Test Plan:
- Reset, then rst held one cycle during EDIT -> dia=1, mes=1, year=0, wr_req=0, busy=0 next cycle.
- Load 31/01/24, select a_mes, inc -> mes=2 and dia clamps to 29 (LEAP_YEAR_EN) or 28 (undefined). Then select a_year, inc -> year=25, dia=28.
- Load dia=31, mes=12, a_dia inc -> dia=1. Then a_mes inc -> mes=1. Then a_year dec from 0 -> year=99.
- inc and dec pulsed in the same cycle with a_dia -> dia unchanged.
- Edit to 07/09/25, drop sw_fecha, ack each write after 3 cycles -> writes (24,07), (25,09), (26,25) in order. wr_req holds stable between acks, and IDLE with busy=0 follows the last ack.
- During WR_MES toggle sw_fecha high -> ignored; burst completes, state returns to IDLE and stays there.

Source files
------------

// File: rtl/fecha_pkg.sv
// Shared types, constants and the days-in-month helper for the date-adjust controller.
// LEAP_YEAR_EN selects the leap-aware February length.
package fecha_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_EDIT,
      S_WR_DIA,
      S_WR_MES,
      S_WR_YEAR
   } state_t;

   localparam logic [7:0] DEF_ADDR_DIA  = 8'h24;
   localparam logic [7:0] DEF_ADDR_MES  = 8'h25;
   localparam logic [7:0] DEF_ADDR_YEAR = 8'h26;

   localparam logic [3:0] MES_MAX  = 4'd12;
   localparam logic [6:0] YEAR_MAX = 7'd99;

   // Only the two low year bits matter: years are 00-99 within one century.
   function automatic logic [4:0] dias_mes(input logic [3:0] mes, input logic [6:0] year);
      logic leap;
`ifdef LEAP_YEAR_EN
      leap = (year[1:0] == 2'b00);
`else
      leap = 1'b0;
`endif
      case (mes)
         4'd2:                       return leap ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:    return 5'd30;
         default:                    return 5'd31;
      endcase
   endfunction

endpackage

// File: rtl/bin_a_bcd.sv
// Combinational binary (0-99) to two-digit packed BCD converter.
module bin_a_bcd (
   input  logic [6:0] bin,
   output logic [7:0] bcd
);

   logic [3:0] tens;
   logic [3:0] ones;

   // Largest multiple of ten not above the input gives the tens digit.
   always_comb begin
      tens = 4'd0;
      ones = bin[3:0];
      for (int t = 1; t <= 9; t++) begin
         if (bin >= 7'(t * 10)) begin
            tens = 4'(t);
            ones = 4'(bin - 7'(t * 10));
         end
      end
   end

   assign bcd = {tens, ones};

endmodule

// File: rtl/ctrl_valores_fecha.sv
// Date-adjust controller: edits day/month/year with calendar wrap and clamp, then
// writes the three fields to the RTC as BCD. LEAP_YEAR_EN enables leap-year February.
module ctrl_valores_fecha
   import fecha_pkg::*;
#(
   parameter logic [7:0] ADDR_DIA  = DEF_ADDR_DIA,
   parameter logic [7:0] ADDR_MES  = DEF_ADDR_MES,
   parameter logic [7:0] ADDR_YEAR = DEF_ADDR_YEAR
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sw_fecha,
   input  logic       a_dia,
   input  logic       a_mes,
   input  logic       a_year,
   input  logic       inc,
   input  logic       dec,
   input  logic [4:0] dia_in,
   input  logic [3:0] mes_in,
   input  logic [6:0] year_in,
   input  logic       wr_ack,
   output logic [4:0] dia,
   output logic [3:0] mes,
   output logic [6:0] year,
   output logic       wr_req,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       busy
);

   state_t     state_q, state_d;
   logic       sw_prev_q;
   logic [4:0] dia_q, dia_d;
   logic [3:0] mes_q, mes_d;
   logic [6:0] year_q, year_d;
   logic       wr_req_q, wr_req_d;
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       busy_q, busy_d;

   logic       sw_rise, sw_fall;
   logic       up, dn;
   logic [3:0] mes_step;
   logic [6:0] year_step;
   logic [4:0] dia_max_cur, dia_max_mes;
   logic [6:0] bcd_src;
   logic [7:0] bcd_out;

   assign sw_rise = sw_fecha & ~sw_prev_q;
   assign sw_fall = ~sw_fecha & sw_prev_q;
   assign up      = inc & ~dec;
   assign dn      = dec & ~inc;

   always_comb begin
      mes_step  = mes_q;
      year_step = year_q;
      if (up) begin
         mes_step  = (mes_q >= MES_MAX)   ? 4'd1 : mes_q + 4'd1;
         year_step = (year_q >= YEAR_MAX) ? 7'd0 : year_q + 7'd1;
      end else if (dn) begin
         mes_step  = (mes_q <= 4'd1)  ? MES_MAX  : mes_q - 4'd1;
         year_step = (year_q == 7'd0) ? YEAR_MAX : year_q - 7'd1;
      end
   end

   assign dia_max_cur = dias_mes(mes_q, year_q);
   assign dia_max_mes = dias_mes(mes_step, year_q);

   always_comb begin
      state_d = state_q;
      dia_d   = dia_q;
      mes_d   = mes_q;
      year_d  = year_q;
      case (state_q)
         S_IDLE: begin
            if (sw_rise) state_d = S_LOAD;
         end
         S_LOAD: begin
            dia_d   = (dia_in == 5'd0) ? 5'd1 : dia_in;
            mes_d   = (mes_in == 4'd0 || mes_in > MES_MAX) ? 4'd1 : mes_in;
            year_d  = (year_in > YEAR_MAX) ? 7'd0 : year_in;
            state_d = S_EDIT;
         end
         S_EDIT: begin
            // Fields freeze on the exit cycle so the burst writes what was shown.
            if (sw_fall) begin
               state_d = S_WR_DIA;
            end else if (up || dn) begin
               if (a_dia) begin
                  if (up) dia_d = (dia_q >= dia_max_cur) ? 5'd1 : dia_q + 5'd1;
                  else    dia_d = (dia_q <= 5'd1) ? dia_max_cur : dia_q - 5'd1;
               end else if (a_mes) begin
                  mes_d = mes_step;
                  if (dia_q > dia_max_mes) dia_d = dia_max_mes;
               end else if (a_year) begin
                  year_d = year_step;
`ifdef LEAP_YEAR_EN
                  if (dia_q > dias_mes(mes_q, year_step)) dia_d = dias_mes(mes_q, year_step);
`endif
               end
            end
         end
         S_WR_DIA:  if (wr_ack) state_d = S_WR_MES;
         S_WR_MES:  if (wr_ack) state_d = S_WR_YEAR;
         S_WR_YEAR: if (wr_ack) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      case (state_d)
         S_WR_DIA: bcd_src = {2'b00, dia_q};
         S_WR_MES: bcd_src = {3'b000, mes_q};
         default:  bcd_src = year_q;
      endcase
   end

   bin_a_bcd u_bin_a_bcd (
      .bin (bcd_src),
      .bcd (bcd_out)
   );

   // Write outputs are decided from the next state so they line up with it.
   always_comb begin
      wr_req_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      busy_d    = (state_d != S_IDLE);
      case (state_d)
         S_WR_DIA: begin
            wr_req_d  = 1'b1;
            wr_addr_d = ADDR_DIA;
            wr_data_d = bcd_out;
         end
         S_WR_MES: begin
            wr_req_d  = 1'b1;
            wr_addr_d = ADDR_MES;
            wr_data_d = bcd_out;
         end
         S_WR_YEAR: begin
            wr_req_d  = 1'b1;
            wr_addr_d = ADDR_YEAR;
            wr_data_d = bcd_out;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sw_prev_q <= 1'b0;
         dia_q     <= 5'd1;
         mes_q     <= 4'd1;
         year_q    <= 7'd0;
         wr_req_q  <= 1'b0;
         wr_addr_q <= 8'h00;
         wr_data_q <= 8'h00;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sw_prev_q <= sw_fecha;
         dia_q     <= dia_d;
         mes_q     <= mes_d;
         year_q    <= year_d;
         wr_req_q  <= wr_req_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
      end
   end

   assign dia     = dia_q;
   assign mes     = mes_q;
   assign year    = year_q;
   assign wr_req  = wr_req_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = busy_q;

endmodule
